// File: rtl/output_collector_block_if.sv
// Collector bundle: softmax result words in, buffered vector stream out.
// Master drives inputs and out_ready_i; slave (the collector) drives the output stream and status.
interface output_collector_block_if #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10
);
    localparam int IDX_W = $clog2(number_of_data);

    logic [data_size-1:0] collect_data_i;
    logic                 collect_data_valid_i;
    logic                 out_ready_i;
    logic [data_size-1:0] out_data_o;
    logic                 out_valid_o;
    logic                 out_last_o;
    logic [IDX_W-1:0]     out_index_o;
    logic                 busy_o;
    logic                 overflow_o;

    modport master (
        output collect_data_i, collect_data_valid_i, out_ready_i,
        input  out_data_o, out_valid_o, out_last_o, out_index_o, busy_o, overflow_o
    );

    modport slave (
        input  collect_data_i, collect_data_valid_i, out_ready_i,
        output out_data_o, out_valid_o, out_last_o, out_index_o, busy_o, overflow_o
    );
endinterface

// File: rtl/output_collector_block.sv
// Buffers one softmax vector, then streams it out; first word 1 cycle after the last capture.
// Output holds under out_ready_i=0; words arriving while draining are dropped and flag overflow.
module output_collector_block #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    output_collector_block_if.slave   bus
);
    localparam int               IDX_W    = $clog2(number_of_data);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(number_of_data - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_en;
    logic [data_size-1:0] buffer_q [number_of_data];

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.collect_data_valid_i) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                // No room while draining: the word is lost, only the sticky flag records it.
                if (bus.collect_data_valid_i) begin
                    overflow_d = 1'b1;
                end
                if (bus.out_ready_i) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_d = '0;
                        state_d  = COLLECT;
                    end else begin
                        rd_cnt_d = rd_cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= COLLECT;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            buffer_q[wr_cnt_q] <= bus.collect_data_i;
        end
    end

    // Buffer is never reset, so the data path is forced to zero outside DRAIN.
    assign bus.out_valid_o = (state_q == DRAIN);
    assign bus.out_data_o  = (state_q == DRAIN) ? buffer_q[rd_cnt_q] : '0;
    assign bus.out_index_o = rd_cnt_q;
    assign bus.out_last_o  = (state_q == DRAIN) && (rd_cnt_q == LAST_IDX);
    assign bus.busy_o      = !((state_q == COLLECT) && (wr_cnt_q == '0));
    assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_output_collector_block.sv
module tb_output_collector_block;
    localparam int DW = 32;
    localparam int N  = 10;

    logic clock_i   = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clock_i = ~clock_i;

    output_collector_block_if #(.data_size(DW), .number_of_data(N)) bus ();

    output_collector_block #(.data_size(DW), .number_of_data(N)) dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: words gathered so far, and the vector still waiting to be accepted downstream.
    logic [DW-1:0] col [$];
    logic [DW-1:0] drn [$];
    bit            ovf;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        bit            v;
        logic [DW-1:0] exp_data;
        int            exp_idx;
        v        = (drn.size() > 0);
        exp_data = v ? drn[0] : '0;
        exp_idx  = v ? (N - drn.size()) : 0;
        chk({ph, ".valid"}, DW'(bus.out_valid_o), DW'(v));
        chk({ph, ".data"},  bus.out_data_o,       exp_data);
        chk({ph, ".index"}, DW'(bus.out_index_o), DW'(exp_idx));
        chk({ph, ".last"},  DW'(bus.out_last_o),  DW'(drn.size() == 1));
        chk({ph, ".busy"},  DW'(bus.busy_o),      DW'(v || col.size() != 0));
        chk({ph, ".ovf"},   DW'(bus.overflow_o),  DW'(ovf));
    endtask

    // One clock: check what the DUT shows now, drive the next inputs, advance the reference.
    task automatic cyc(input string ph, input bit v, input logic [DW-1:0] d, input bit rdy);
        @(negedge clock_i);
        check_outputs(ph);
        bus.collect_data_valid_i = v;
        bus.collect_data_i       = d;
        bus.out_ready_i          = rdy;
        if (drn.size() > 0) begin
            if (v) ovf = 1'b1;
            if (rdy) void'(drn.pop_front());
        end else if (v) begin
            col.push_back(d);
            if (col.size() == N) begin
                drn = col;
                col.delete();
            end
        end
    endtask

    task automatic do_reset(input string ph);
        @(negedge clock_i);
        reset_n_i                = 1'b0;
        bus.collect_data_valid_i = 1'b0;
        bus.collect_data_i       = '0;
        bus.out_ready_i          = 1'b0;
        #1;
        col.delete();
        drn.delete();
        ovf = 1'b0;
        check_outputs(ph);
        @(negedge clock_i);
        reset_n_i = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 1'b0, '0, 1'b1);
    endtask

    initial begin
        bus.collect_data_valid_i = 1'b0;
        bus.collect_data_i       = '0;
        bus.out_ready_i          = 1'b0;
        ovf                      = 1'b0;

        do_reset("reset");

        // Basic vector, then a second vector starting right after the final transfer.
        for (int i = 1; i <= N; i++) cyc("basic_in", 1'b1, DW'(i), 1'b1);
        for (int i = 0; i < N; i++) cyc("basic_out", 1'b0, '0, 1'b1);
        for (int i = 0; i < N; i++) cyc("b2b_in", 1'b1, DW'(32'h100 + i), 1'b1);
        idle(N + 2);

        // Gapped input: one word every third cycle.
        for (int i = 0; i < 3 * N; i++)
            cyc("gapped", (i % 3) == 0, DW'(32'h200 + i / 3), 1'b1);
        idle(N + 2);

        // Random data, random gaps and random backpressure; no words offered while draining.
        for (int i = 0; i < 400; i++)
            cyc("bp", (drn.size() == 0) && ($urandom_range(0, 2) != 0), DW'($urandom),
                $urandom_range(0, 1) == 1);
        while (drn.size() > 0) cyc("bp_flush", 1'b0, '0, 1'b1);
        while (col.size() > 0) cyc("bp_fill", 1'b1, DW'($urandom), 1'b1);
        idle(N + 2);

        // One word injected mid-drain, with a stall in the middle of the drain.
        for (int i = 0; i < N; i++) cyc("ovf_in", 1'b1, DW'($urandom), 1'b1);
        for (int i = 0; i < N + 2; i++)
            cyc("ovf_drain", i == 3, DW'(32'hDEAD_BEEF), i != 5);
        idle(3);

        // Reset after five words, then a fresh vector.
        for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, DW'(32'hBAD0 + i), 1'b1);
        do_reset("reset_mid_collect");
        for (int i = 0; i < N; i++) cyc("post_rst", 1'b1, DW'(32'h300 + i), 1'b1);
        idle(N + 2);

        // Reset part way through a drain.
        for (int i = 0; i < N; i++) cyc("pre_rst2", 1'b1, DW'(32'h400 + i), 1'b1);
        for (int i = 0; i < 3; i++) cyc("part_drain", 1'b0, '0, 1'b1);
        do_reset("reset_mid_drain");
        for (int i = 0; i < N; i++) cyc("post_rst2", 1'b1, DW'(32'h500 + i), 1'b1);

        // A word offered on the final transfer cycle is dropped too.
        for (int i = 0; i < N; i++) cyc("last_drop", i == N - 1, DW'(32'hFACE), 1'b1);
        idle(2);
        for (int i = 0; i < N; i++) cyc("after_drop", 1'b1, DW'(32'h600 + i), 1'b1);
        idle(N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
